// File: rtl/node_sigma_rx_pkg.sv
// node_sigma_rx_pkg
//   Shared types and helpers for the sigma link receiver.
//   - state_t       : frame-reduction FSM states
//   - beat_width()  : width of a counter that must hold 0..frame_len
//   - pair_bits()   : packed width of one {p, q} pair
package node_sigma_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  function automatic int beat_width(input int frame_len);
    return $clog2(frame_len + 1);
  endfunction

  function automatic int pair_bits(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/sigma_pair_fifo.sv
// sigma_pair_fifo
//   Synchronous FIFO of {p, q} pairs with a combinational head.
//   Ports:
//     clk, rst_n        clock, async active-low reset (empties the FIFO)
//     push, push_p/q    write request and pair data (ignored when full)
//     pop               read request (ignored when empty)
//     head_p, head_q    oldest entry, valid whenever empty==0
//     full, empty       occupancy flags
//     count             number of stored pairs, 0..DEPTH
module sigma_pair_fifo
  import node_sigma_rx_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_p,
  input  logic [WIDTH-1:0] push_q,
  input  logic             pop,
  output logic [WIDTH-1:0] head_p,
  output logic [WIDTH-1:0] head_q,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  typedef struct packed {
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] q;
  } pair_t;

  pair_t         mem [DEPTH];
  pair_t         wr_pair;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign wr_pair = '{p: push_p, q: push_q};
  assign head_p  = mem[rd_ptr].p;
  assign head_q  = mem[rd_ptr].q;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_pair;
  end

  // The packed pair width is fixed by the two channel words.
  if ($bits(pair_t) != pair_bits(WIDTH)) begin : g_bad_pair
    $error("pair_t width does not match two channel words");
  end

endmodule

// File: rtl/node_sigma_rx.sv
// node_sigma_rx
//   Receive end of the sigma dual-channel link. Buffers {p, q} pairs and
//   reduces each frame of FRAME_LEN pairs (or a shorter flushed frame) to
//   a modular p-sum, a q-XOR and a beat count.
//   Ports:
//     clk, rst_n              clock, async active-low reset
//     in_valid/in_ready       input pair handshake; in_ready = FIFO not full
//     in_p, in_q              channel words
//     flush                   single-cycle pulse closing the current partial frame
//     out_valid/out_ready     frame result handshake
//     out_sum, out_xor        p-sum mod 2^WIDTH, q-XOR (registered)
//     out_len                 beats in the frame (registered)
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no frame open; first available pair opens one
//   ST_ACCUM | frame open; fold one pair per cycle until full or flushed
//   ST_HOLD  | result presented on out_*; waits for out_ready, never pops
module node_sigma_rx
  import node_sigma_rx_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 4,
  parameter int FRAME_LEN = 4,
  localparam int BEAT_W = beat_width(FRAME_LEN),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_p,
  input  logic [WIDTH-1:0]  in_q,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_sum,
  output logic [WIDTH-1:0]  out_xor,
  output logic [BEAT_W-1:0] out_len
);

  state_t             state;
  state_t             state_nx;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [WIDTH-1:0]   head_p;
  logic [WIDTH-1:0]   head_q;

  logic [WIDTH-1:0]   acc_sum;
  logic [WIDTH-1:0]   acc_xor;
  logic [BEAT_W-1:0]  beat;
  logic               flush_pending;

  logic [WIDTH-1:0]   acc_sum_nx;
  logic [WIDTH-1:0]   acc_xor_nx;
  logic [BEAT_W-1:0]  beat_nx;
  logic               flush_pending_nx;
  logic               out_valid_nx;
  logic [WIDTH-1:0]   out_sum_nx;
  logic [WIDTH-1:0]   out_xor_nx;
  logic [BEAT_W-1:0]  out_len_nx;

  logic               last_beat;
  logic               enter_hold;

  // in_ready looks only at the stored count, so a pop in the same cycle
  // does not make room until the following cycle.
  assign in_ready  = (fifo_count != CNT_W'(DEPTH));
  assign fifo_push = in_valid && !fifo_full;

  sigma_pair_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (fifo_push),
    .push_p (in_p),
    .push_q (in_q),
    .pop    (fifo_pop),
    .head_p (head_p),
    .head_q (head_q),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  // True when the pair about to be folded in completes a full frame.
  assign last_beat = (beat == BEAT_W'(FRAME_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) state_nx = (FRAME_LEN == 1) ? ST_HOLD : ST_ACCUM;
      end
      ST_ACCUM: begin
        // Buffered data is always drained before a flush closes the frame.
        if (!fifo_empty) begin
          if (last_beat) state_nx = ST_HOLD;
        end else if (flush_pending) begin
          state_nx = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign enter_hold = (state != ST_HOLD) && (state_nx == ST_HOLD);

  always_comb begin
    fifo_pop         = 1'b0;
    acc_sum_nx       = acc_sum;
    acc_xor_nx       = acc_xor;
    beat_nx          = beat;
    flush_pending_nx = flush_pending;
    out_valid_nx     = out_valid;
    out_sum_nx       = out_sum;
    out_xor_nx       = out_xor;
    out_len_nx       = out_len;

    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          acc_sum_nx = head_p;
          acc_xor_nx = head_q;
          beat_nx    = BEAT_W'(1);
        end
      end
      ST_ACCUM: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          acc_sum_nx = acc_sum + head_p;
          acc_xor_nx = acc_xor ^ head_q;
          beat_nx    = beat + BEAT_W'(1);
        end
      end
      default: ;
    endcase

    // Results are captured once on entry to HOLD and then left alone, so
    // they stay stable while waiting and keep their value afterwards.
    if (enter_hold) begin
      out_valid_nx = 1'b1;
      out_sum_nx   = acc_sum_nx;
      out_xor_nx   = acc_xor_nx;
      out_len_nx   = beat_nx;
    end else if (state == ST_HOLD && out_ready) begin
      out_valid_nx = 1'b0;
    end

    // Closing a frame consumes the pending flush; a new pulse in that same
    // cycle is ordered after it and so belongs to the next frame.
    if (state == ST_ACCUM && state_nx == ST_HOLD) flush_pending_nx = 1'b0;
    if (flush && !(state == ST_IDLE && fifo_empty)) flush_pending_nx = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_sum       <= '0;
      acc_xor       <= '0;
      beat          <= '0;
      flush_pending <= 1'b0;
      out_valid     <= 1'b0;
      out_sum       <= '0;
      out_xor       <= '0;
      out_len       <= '0;
    end else begin
      acc_sum       <= acc_sum_nx;
      acc_xor       <= acc_xor_nx;
      beat          <= beat_nx;
      flush_pending <= flush_pending_nx;
      out_valid     <= out_valid_nx;
      out_sum       <= out_sum_nx;
      out_xor       <= out_xor_nx;
      out_len       <= out_len_nx;
    end
  end

endmodule

// File: tb/tb_node_sigma_rx.sv
// tb_node_sigma_rx
//   Directed scoreboard bench for node_sigma_rx (WIDTH=32, DEPTH=4,
//   FRAME_LEN=4). Stimulus pushes expected frame results into a queue; a
//   monitor on the falling edge pops and compares on each out handshake
//   and checks that a waiting result stays valid and stable.
module tb_node_sigma_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_p;
  logic [31:0] in_q;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic [31:0] out_xor;
  logic [2:0]  out_len;

  node_sigma_rx #(
    .WIDTH     (32),
    .DEPTH     (4),
    .FRAME_LEN (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_p      (in_p),
    .in_q      (in_q),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_xor   (out_xor),
    .out_len   (out_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] s;
    logic [31:0] x;
    logic [31:0] l;
  } exp_t;

  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int valid_cycles = 0;
  int hs_cyc = 0;
  int last_push_cyc = 0;

  logic        waiting = 1'b0;
  logic [31:0] held_sum, held_xor, held_len;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic exp_push(input logic [31:0] s, input logic [31:0] x, input logic [31:0] l);
    exp_t e;
    e.s = s; e.x = x; e.l = l;
    exp_q.push_back(e);
  endtask

  // Monitor: handshake at the next rising edge when out_valid && out_ready.
  always @(negedge clk) begin
    if (!rst_n) begin
      waiting = 1'b0;
    end else begin
      if (waiting) begin
        chk("valid_held", {31'd0, out_valid}, 32'd1);
        chk("sum_stable", out_sum, held_sum);
        chk("xor_stable", out_xor, held_xor);
        chk("len_stable", {29'd0, out_len}, held_len);
      end
      if (out_valid) begin
        valid_cycles++;
        if (out_ready) begin
          hs_cyc = cyc + 1;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_frame: got sum=%0h xor=%0h len=%0d, expected no frame",
                     out_sum, out_xor, out_len);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("out_sum", out_sum, e.s);
            chk("out_xor", out_xor, e.x);
            chk("out_len", {29'd0, out_len}, e.l);
          end
          waiting = 1'b0;
        end else begin
          waiting  = 1'b1;
          held_sum = out_sum;
          held_xor = out_xor;
          held_len = {29'd0, out_len};
        end
      end else begin
        waiting = 1'b0;
      end
    end
  end

  task automatic push(input logic [31:0] p, input logic [31:0] q);
    int g;
    g = 0;
    in_valid = 1'b1;
    in_p = p;
    in_q = q;
    while (!in_ready && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 200) chk("push_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    last_push_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 500) begin
      @(posedge clk);
      g++;
    end
    #1;
    chk({name, "_drain_left"}, exp_q.size(), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vc0, pc0, n, g;
    logic acc;

    // Reset with random inputs.
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_p      = $urandom;
      in_q      = $urandom;
      flush     = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_sum", out_sum, 32'd0);
    chk("rst_out_xor", out_xor, 32'd0);
    chk("rst_out_len", {29'd0, out_len}, 32'd0);
    in_valid = 1'b0; in_p = '0; in_q = '0; flush = 1'b0; out_ready = 1'b1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("idle_no_valid", valid_cycles, 32'd0);

    // Full frame, back-to-back.
    vc0 = valid_cycles;
    exp_push(32'd10, 32'hF, 32'd4);
    push(32'd1, 32'h1); pc0 = last_push_cyc;
    push(32'd2, 32'h2);
    push(32'd3, 32'h4);
    push(32'd4, 32'h8);
    wait_drain("full");
    chk("full_valid_cycles", valid_cycles - vc0, 32'd1);
    chk("full_latency", hs_cyc - pc0, 32'd5);

    // Modular wrap of the sum, XOR cancelling.
    exp_push(32'd0, 32'd0, 32'd4);
    push(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    push(32'd1, 32'd0);
    push(32'd0, 32'd0);
    push(32'd0, 32'hFFFF_FFFF);
    wait_drain("wrap");

    // Backpressure: p=n, q=3n, continuous valid.
    out_ready = 1'b0;
    exp_push(32'd6,  32'hC,  32'd4);
    exp_push(32'd22, 32'h4,  32'd4);
    exp_push(32'd38, 32'h3C, 32'd4);
    n = 0; g = 0;
    in_valid = 1'b1;
    while (n < 8 && g < 100) begin
      in_p = n; in_q = 3 * n;
      acc = in_ready;
      @(posedge clk); #1;
      g++;
      if (acc) n++;
    end
    in_p = n; in_q = 3 * n;
    repeat (5) @(posedge clk);
    #1;
    chk("bp_accepted", n, 32'd8);
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_hold_sum", out_sum, 32'd6);
    out_ready = 1'b1;
    g = 0;
    while (n < 12 && g < 100) begin
      in_p = n; in_q = 3 * n;
      acc = in_ready;
      @(posedge clk); #1;
      g++;
      if (acc) n++;
    end
    in_valid = 1'b0;
    wait_drain("bp");

    // Flush closes a partial frame of two.
    exp_push(32'd12, 32'd0, 32'd2);
    push(32'd5, 32'hA);
    push(32'd7, 32'hA);
    pulse_flush();
    wait_drain("flush2");

    // Flush in IDLE with an empty FIFO is dropped: a gapped frame stays full.
    vc0 = valid_cycles;
    pulse_flush();
    repeat (10) @(posedge clk);
    #1;
    chk("idle_flush_no_valid", valid_cycles - vc0, 32'd0);
    exp_push(32'd10, 32'hF, 32'd4);
    push(32'd1, 32'h1);
    repeat (4) @(posedge clk);
    #1;
    push(32'd2, 32'h2);
    push(32'd3, 32'h4);
    push(32'd4, 32'h8);
    wait_drain("idle_flush");

    // Flush during HOLD applies to the next frame, which has one pair.
    out_ready = 1'b0;
    exp_push(32'd4, 32'd0, 32'd4);
    exp_push(32'h55, 32'h66, 32'd1);
    push(32'd1, 32'd1);
    push(32'd1, 32'd1);
    push(32'd1, 32'd1);
    push(32'd1, 32'd1);
    g = 0;
    while (!out_valid && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    chk("hold_reached", {31'd0, out_valid}, 32'd1);
    pulse_flush();
    push(32'h55, 32'h66);
    out_ready = 1'b1;
    wait_drain("hold_flush");

    // Reset mid-frame: two pairs popped, one buffered.
    push(32'd9, 32'd9);
    push(32'd9, 32'd9);
    push(32'd9, 32'd9);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_out_sum", out_sum, 32'd0);
    chk("midrst_out_xor", out_xor, 32'd0);
    chk("midrst_out_len", {29'd0, out_len}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp_push(32'd4, 32'hF0, 32'd4);
    push(32'd1, 32'h10);
    push(32'd1, 32'h20);
    push(32'd1, 32'h40);
    push(32'd1, 32'h80);
    wait_drain("midrst");

    repeat (5) @(posedge clk);
    #1;
    chk("final_queue_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
